// File: rtl/prbs16_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs16_checker
//  Description : Self-check for the 16-bit Galois LFSR pattern generator.
//                Samples the generator state word on every valid cycle and
//                predicts the next word with x^16+x^14+x^13+x^11+1. It
//                acquires lock, flags and counts mismatches, and measures
//                the number of valid samples between occurrences of SEED.
//  Ports       : CLK          - system clock, rising edge
//                n_RESET      - asynchronous active-low reset
//                D[15:0]      - generator state word
//                VALID        - D is sampled only when high
//                LOCKED       - checker is locked to the sequence
//                ERR          - one-cycle pulse per mismatch while locked
//                ERR_COUNT    - saturating mismatch count (reset-only clear)
//                PERIOD[16:0] - valid samples between the last two SEEDs
//                PERIOD_VALID - one-cycle pulse when PERIOD updates
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs16_checker #(
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned ERR_W    = 8
) (
   input  logic              CLK,
   input  logic              n_RESET,
   input  logic [15:0]       D,
   input  logic              VALID,
   output logic              LOCKED,
   output logic              ERR,
   output logic [ERR_W-1:0]  ERR_COUNT,
   output logic [16:0]       PERIOD,
   output logic              PERIOD_VALID
);

   localparam logic [15:0] c_POLY    = 16'hB400;
   localparam logic [3:0]  c_LOCK    = LOCK_CNT[3:0];
   localparam logic [3:0]  c_LOSS    = LOSS_CNT[3:0];
   localparam logic [16:0] c_PER_MAX = 17'h1FFFF;
   localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   function automatic logic [15:0] f_step(input logic [15:0] x);
      return {1'b0, x[15:1]} ^ (x[0] ? c_POLY : 16'h0000);
   endfunction

   state_t           r_state, w_state_next;
   logic [15:0]      r_pred, w_pred_next;
   logic [3:0]       r_match_cnt, w_match_next;
   logic [3:0]       r_miss_cnt, w_miss_next;
   logic [16:0]      r_per_cnt, w_per_next;
   logic             r_seen_seed, w_seen_next;
   logic             r_locked;
   logic             r_err, w_err_next;
   logic [ERR_W-1:0] r_err_count, w_cnt_next;
   logic [16:0]      r_period, w_period_next;
   logic             r_period_valid, w_pv_next;

   logic [3:0]       w_match_inc;
   logic [3:0]       w_miss_inc;
   logic [16:0]      w_per_inc;
   logic             w_hit;

   assign w_match_inc = r_match_cnt + 4'd1;
   assign w_miss_inc  = r_miss_cnt + 4'd1;
   assign w_per_inc   = (r_per_cnt == c_PER_MAX) ? r_per_cnt : r_per_cnt + 17'd1;
   assign w_hit       = (D == r_pred);

   always_comb begin
      w_state_next  = r_state;
      w_pred_next   = r_pred;
      w_match_next  = r_match_cnt;
      w_miss_next   = r_miss_cnt;
      w_per_next    = r_per_cnt;
      w_seen_next   = r_seen_seed;
      w_err_next    = 1'b0;
      w_cnt_next    = r_err_count;
      w_period_next = r_period;
      w_pv_next     = 1'b0;
      if (VALID) begin
         case (r_state)
            ST_HUNT: begin
               if (D != 16'h0000) begin
                  w_pred_next  = f_step(D);
                  w_match_next = 4'd0;
                  w_state_next = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (w_hit) begin
                  w_match_next = w_match_inc;
                  w_pred_next  = f_step(D);
                  if (w_match_inc == c_LOCK) begin
                     // Start the locked phase with clean loss/period tracking.
                     w_state_next = ST_LOCKED;
                     w_miss_next  = 4'd0;
                     w_per_next   = 17'd0;
                     w_seen_next  = 1'b0;
                  end
               end else if (D == 16'h0000) begin
                  w_state_next = ST_HUNT;
               end else begin
                  w_pred_next  = f_step(D);
                  w_match_next = 4'd0;
               end
            end
            ST_LOCKED: begin
               // Free-running predictor: one bad word costs exactly one error.
               w_pred_next = f_step(r_pred);
               if (w_hit) begin
                  w_miss_next = 4'd0;
               end else begin
                  w_err_next  = 1'b1;
                  w_miss_next = w_miss_inc;
                  if (r_err_count != c_ERR_MAX) begin
                     w_cnt_next = r_err_count + c_ERR_ONE;
                  end
               end
               // Loss of lock takes precedence over period bookkeeping.
               if (!w_hit && (w_miss_inc == c_LOSS)) begin
                  w_state_next = ST_HUNT;
                  w_per_next   = 17'd0;
                  w_seen_next  = 1'b0;
               end else if (D == SEED) begin
                  if (r_seen_seed) begin
                     w_period_next = w_per_inc;
                     w_pv_next     = 1'b1;
                  end
                  w_per_next  = 17'd0;
                  w_seen_next = 1'b1;
               end else begin
                  w_per_next = w_per_inc;
               end
            end
            default: w_state_next = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge n_RESET) begin
      if (!n_RESET) begin
         r_state        <= ST_HUNT;
         r_pred         <= 16'h0000;
         r_match_cnt    <= 4'd0;
         r_miss_cnt     <= 4'd0;
         r_per_cnt      <= 17'd0;
         r_seen_seed    <= 1'b0;
         r_locked       <= 1'b0;
         r_err          <= 1'b0;
         r_err_count    <= '0;
         r_period       <= 17'd0;
         r_period_valid <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_pred         <= w_pred_next;
         r_match_cnt    <= w_match_next;
         r_miss_cnt     <= w_miss_next;
         r_per_cnt      <= w_per_next;
         r_seen_seed    <= w_seen_next;
         r_locked       <= (w_state_next == ST_LOCKED);
         r_err          <= w_err_next;
         r_err_count    <= w_cnt_next;
         r_period       <= w_period_next;
         r_period_valid <= w_pv_next;
      end
   end

   assign LOCKED       = r_locked;
   assign ERR          = r_err;
   assign ERR_COUNT    = r_err_count;
   assign PERIOD       = r_period;
   assign PERIOD_VALID = r_period_valid;

endmodule
`default_nettype wire
